// File: rtl/best_arr_sender_pkg.sv
// Shared definitions for the best-match result sender: state encoding, default sizing
// and the blocked scan-order address mapping.
package best_arr_sender_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_IDX,
        S_SEND_DIST,
        S_DRAIN,
        S_DONE
    } sender_state_t;

    typedef enum logic [1:0] {
        SRC_IDX,
        SRC_DIST_LO,
        SRC_DIST_HI
    } word_src_t;

    localparam int unsigned DEF_DATA_WIDTH      = 11;
    localparam int unsigned DEF_ROW_SIZE        = 32;
    localparam int unsigned DEF_COL_SIZE        = 16;
    localparam int unsigned DEF_BLOCKING        = 4;
    localparam int unsigned DEF_NUM_QUERYS      = DEF_ROW_SIZE * DEF_COL_SIZE;
    localparam int unsigned DEF_QADDR_W         = $clog2(DEF_NUM_QUERYS);
    localparam int unsigned DEF_WORDS_PER_START = 3 * DEF_NUM_QUERYS;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned scan_addr(input int unsigned px, input int unsigned x,
                                              input int unsigned y, input int unsigned xi,
                                              input int unsigned row_size,
                                              input int unsigned blocking);
        return px * (row_size / 2) + y * row_size + x * blocking + xi;
    endfunction

endpackage

// File: rtl/sender_skid_fifo.sv
// Two-entry skid buffer between the result-memory read pipeline and the output FIFO.
module sender_skid_fifo #(
    parameter int unsigned DATA_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/best_arr_sender.sv
// Streams best-index then best-distance (low/high halves) words in blocked scan order
// into the output FIFO, flow-controlled through a small skid buffer.
module best_arr_sender
    import best_arr_sender_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned ROW_SIZE   = 32,
    parameter int unsigned COL_SIZE   = 16,
    parameter int unsigned BLOCKING   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   send_best_arr,
    output logic                                   idx_rd_en,
    output logic                                   dist_rd_en,
    output logic [$clog2(ROW_SIZE*COL_SIZE)-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]                  idx_rd_data,
    input  logic [2*DATA_WIDTH-1:0]                dist_rd_data,
    output logic                                   out_fifo_wenq,
    output logic [DATA_WIDTH-1:0]                  out_fifo_wdata,
    input  logic                                   out_fifo_wfull_n,
    output logic                                   busy,
    output logic                                   send_done
);

    localparam int unsigned NUM_QUERYS = ROW_SIZE * COL_SIZE;
    localparam int unsigned QADDR_W    = $clog2(NUM_QUERYS);
    localparam int unsigned X_BLOCKS   = ROW_SIZE / 2 / BLOCKING;
    localparam int unsigned XI_W       = cnt_width(BLOCKING);
    localparam int unsigned Y_W        = cnt_width(COL_SIZE);
    localparam int unsigned X_W        = cnt_width(X_BLOCKS);

    localparam logic [XI_W-1:0] XI_MAX = XI_W'(BLOCKING - 1);
    localparam logic [Y_W-1:0]  Y_MAX  = Y_W'(COL_SIZE - 1);
    localparam logic [X_W-1:0]  X_MAX  = X_W'(X_BLOCKS - 1);

    sender_state_t state, state_next;

    logic            start_q;
    logic            start_accept;
    logic [XI_W-1:0] xi;
    logic [Y_W-1:0]  y;
    logic [X_W-1:0]  x;
    logic            px;
    logic            agg;
    logic            last_query;
    logic            adv_query;
    logic            issue;
    logic            pend;
    word_src_t       pend_src;
    logic [DATA_WIDTH-1:0] dist_hi;
    logic [DATA_WIDTH-1:0] push_data;
    logic            skid_full;
    logic            skid_empty;
    logic            pop;
    logic [1:0]      level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_next;
            start_q <= send_best_arr;
        end
    end

    assign pop        = !skid_empty && out_fifo_wfull_n;
    assign last_query = px && (x == X_MAX) && (y == Y_MAX) && (xi == XI_MAX);

    always_comb begin
        state_next   = state;
        start_accept = 1'b0;
        issue        = 1'b0;
        idx_rd_en    = 1'b0;
        dist_rd_en   = 1'b0;
        adv_query    = 1'b0;
        // Credit: a read may issue only if the word it returns is guaranteed a skid slot.
        level        = (skid_full ? 2'd2 : (skid_empty ? 2'd0 : 2'd1)) + {1'b0, pend};
        case (state)
            S_IDLE, S_DONE: begin
                if (send_best_arr && !start_q) begin
                    start_accept = 1'b1;
                    state_next   = S_SEND_IDX;
                end
            end
            S_SEND_IDX: begin
                issue     = (level < 2'd2) || pop;
                idx_rd_en = issue;
                adv_query = issue;
                if (issue && last_query) state_next = S_SEND_DIST;
            end
            S_SEND_DIST: begin
                issue      = (level < 2'd2) || pop;
                dist_rd_en = issue && !agg;
                adv_query  = issue && agg;
                if (issue && agg && last_query) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!pend && skid_empty) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xi  <= '0;
            y   <= '0;
            x   <= '0;
            px  <= 1'b0;
            agg <= 1'b0;
        end else if (start_accept) begin
            xi  <= '0;
            y   <= '0;
            x   <= '0;
            px  <= 1'b0;
            agg <= 1'b0;
        end else begin
            if (issue && state == S_SEND_DIST) agg <= ~agg;
            if (adv_query) begin
                if (xi == XI_MAX) begin
                    xi <= '0;
                    if (y == Y_MAX) begin
                        y <= '0;
                        if (x == X_MAX) begin
                            x  <= '0;
                            px <= ~px;
                        end else begin
                            x <= x + X_W'(1);
                        end
                    end else begin
                        y <= y + Y_W'(1);
                    end
                end else begin
                    xi <= xi + XI_W'(1);
                end
            end
        end
    end

    // The upper distance half is captured when the low half returns and replayed one slot later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_src <= SRC_IDX;
            dist_hi  <= '0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_src <= (state == S_SEND_IDX) ? SRC_IDX : (agg ? SRC_DIST_HI : SRC_DIST_LO);
            end
            if (pend && pend_src == SRC_DIST_LO) begin
                dist_hi <= dist_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    always_comb begin
        push_data = idx_rd_data;
        case (pend_src)
            SRC_DIST_LO: push_data = dist_rd_data[DATA_WIDTH-1:0];
            SRC_DIST_HI: push_data = dist_hi;
            default:     push_data = idx_rd_data;
        endcase
    end

    sender_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (pend),
        .push_data (push_data),
        .pop       (pop),
        .head      (out_fifo_wdata),
        .full      (skid_full),
        .empty     (skid_empty)
    );

    assign rd_addr       = QADDR_W'(scan_addr(32'(px), 32'(x), 32'(y), 32'(xi), ROW_SIZE, BLOCKING));
    assign out_fifo_wenq = pop;
    assign busy          = (state == S_SEND_IDX) || (state == S_SEND_DIST) || (state == S_DRAIN);
    assign send_done     = (state == S_DONE);

endmodule

// File: tb/tb_best_arr_sender.sv
// Scoreboard bench for best_arr_sender: expected words queued per start, monitor checks each enqueue.
module tb_best_arr_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_best_arr;
    logic        idx_rd_en;
    logic        dist_rd_en;
    logic [8:0]  rd_addr;
    logic [10:0] idx_rd_data;
    logic [21:0] dist_rd_data;
    logic        out_fifo_wenq;
    logic [10:0] out_fifo_wdata;
    logic        out_fifo_wfull_n;
    logic        busy;
    logic        send_done;

    int          vec = 0;
    int          errs = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    bit          throttle = 1'b0;
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];

    always #5 clk = ~clk;

    best_arr_sender #(
        .DATA_WIDTH(11),
        .ROW_SIZE  (32),
        .COL_SIZE  (16),
        .BLOCKING  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .send_best_arr   (send_best_arr),
        .idx_rd_en       (idx_rd_en),
        .dist_rd_en      (dist_rd_en),
        .rd_addr         (rd_addr),
        .idx_rd_data     (idx_rd_data),
        .dist_rd_data    (dist_rd_data),
        .out_fifo_wenq   (out_fifo_wenq),
        .out_fifo_wdata  (out_fifo_wdata),
        .out_fifo_wfull_n(out_fifo_wfull_n),
        .busy            (busy),
        .send_done       (send_done)
    );

    // Result memories: idx_mem[a] = a, dist_mem[a] = {a ^ 0x155, a}, one-cycle read latency.
    always @(posedge clk) begin
        if (idx_rd_en) idx_rd_data <= {2'b00, rd_addr};
        if (dist_rd_en) dist_rd_data <= {({2'b00, rd_addr} ^ 11'h155), {2'b00, rd_addr}};
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        out_fifo_wfull_n = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && out_fifo_wenq === 1'b1) begin
            check("wfull_n_at_wenq", 32'(out_fifo_wfull_n), 32'd1);
            if (exp_q.size() == 0) begin
                vec++;
                errs++;
                $display("FAIL extra_word: got %0h expected no word", out_fifo_wdata);
            end else begin
                check("word", 32'(out_fifo_wdata), 32'(exp_q.pop_front()));
            end
            if (got_q.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            got_q.push_back(out_fifo_wdata);
        end
    end

    task automatic push_stream();
        int unsigned a;
        for (int unsigned ph = 0; ph < 2; ph++)
            for (int unsigned px = 0; px < 2; px++)
                for (int unsigned x = 0; x < 4; x++)
                    for (int unsigned y = 0; y < 16; y++)
                        for (int unsigned xi = 0; xi < 4; xi++) begin
                            a = px * 16 + y * 32 + x * 4 + xi;
                            if (ph == 0) begin
                                exp_q.push_back(11'(a));
                            end else begin
                                exp_q.push_back(11'(a));
                                exp_q.push_back(11'(a) ^ 11'h155);
                            end
                        end
    endtask

    task automatic start_stream();
        got_q.delete();
        @(posedge clk); #1 send_best_arr = 1'b1;
        @(posedge clk); #1 send_best_arr = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("wait_words_reached", 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (send_done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("send_done_reached", 32'(send_done), 32'd1);
    endtask

    task automatic check_spots();
        int          idx [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 64, 256, 512, 513, 514, 515, 1534, 1535};
        logic [10:0] val [16] = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd32, 11'd33, 11'd34, 11'd35,
                                  11'd4, 11'd16, 11'd0, 11'h155, 11'd1, 11'h154, 11'h1ff, 11'h0aa};
        for (int i = 0; i < 16; i++) begin
            if (got_q.size() > idx[i]) check($sformatf("spot_word_%0d", idx[i]), 32'(got_q[idx[i]]), 32'(val[i]));
            else check($sformatf("spot_word_%0d_present", idx[i]), 32'(got_q.size()), 32'(idx[i] + 1));
        end
    endtask

    task automatic check_stream_end(input bit gapless);
        #1;
        check("word_count", 32'(got_q.size()), 32'd1536);
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        if (gapless) check("gapless_span", 32'(last_cyc - first_cyc), 32'd1535);
        check_spots();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wenq"}, 32'(out_fifo_wenq), 32'd0);
        check({tag, "_wdata"}, 32'(out_fifo_wdata), 32'd0);
        check({tag, "_idx_rd_en"}, 32'(idx_rd_en), 32'd0);
        check({tag, "_dist_rd_en"}, 32'(dist_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_send_done"}, 32'(send_done), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        send_best_arr = 1'b0;
        repeat (3) @(posedge clk);
        #2 check_outputs_zero("reset");
        rst = 1'b0;

        // Unthrottled stream, with a stray start pulse mid-stream.
        push_stream();
        start_stream();
        wait_words(100, 400);
        #2 send_best_arr = 1'b1;
        @(posedge clk); #1 send_best_arr = 1'b0;
        @(negedge clk);
        check("busy_after_repulse", 32'(busy), 32'd1);
        wait_done(3000);
        check_stream_end(1'b1);

        // Restart from DONE under random back-pressure.
        push_stream();
        throttle = 1'b1;
        start_stream();
        @(negedge clk);
        check("send_done_cleared", 32'(send_done), 32'd0);
        check("busy_on_restart", 32'(busy), 32'd1);
        wait_done(8000);
        throttle = 1'b0;
        check_stream_end(1'b0);

        // Reset mid-stream, then a clean stream from address 0.
        push_stream();
        start_stream();
        wait_words(700, 2000);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        @(negedge clk);
        check("idle_after_reset_busy", 32'(busy), 32'd0);
        check("idle_after_reset_wenq", 32'(out_fifo_wenq), 32'd0);

        push_stream();
        start_stream();
        wait_done(3000);
        check_stream_end(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
